cla_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for the arithmetic datapath labs. The operand is split into Ancho/Grupo groups. Each group uses 4-bit-style lookahead (G/P) internally. One group is resolved per pipeline stage, and the carry is registered between stages. A valid/ready handshake with backpressure lets the block sit between a stimulus source and a result consumer. It also adds subtract mode and signed status flags.

---
 rtl/cla_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_cla_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe.sv
// cla_pipe: pipelined carry-lookahead adder/subtractor.
// The operand is cut into NG = Ancho/Grupo groups and one group is resolved
// per pipeline stage. Each stage carries the unprocessed upper operand bits
// forward and accumulates the finished lower sum bits. The last stage feeds the
// registered result and flags. A single advance signal freezes every stage under
// backpressure, so bubbles keep their place and no beat is lost or duplicated.
module cla_pipe #(
  parameter int Ancho = 16,
  parameter int Grupo = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Ancho-1:0] A,
  input  logic [Ancho-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Ancho-1:0] S,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero,
  output logic             Neg
);

  localparam int NG = Ancho / Grupo;

  // Two-level lookahead for one group: every carry is a sum of products of the
  // group's G/P bits and the group carry-in, with no dependency on a lower carry.
  function automatic logic [Grupo:0] lookahead(input logic [Grupo-1:0] g,
                                               input logic [Grupo-1:0] p,
                                               input logic             ci);
    logic [Grupo:0] c;
    logic           term;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < Grupo; i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic             rdy_q, rdy_d;
  logic             advance_s;
  logic             accept_s;
  logic             out_valid_q, out_valid_d;
  logic [Ancho-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  assign advance_s = ~out_valid_q | out_ready;
  assign in_ready  = advance_s & rdy_q;
  assign accept_s  = in_valid & in_ready;

  for (genvar k = 0; k < NG; k++) begin : stg
    localparam int LO = k * Grupo;
    localparam int IW = Ancho - LO;

    logic [IW-1:0]       a_in_s;
    logic [IW-1:0]       bx_in_s;
    logic                c_in_s;
    logic                v_in_s;
    logic [Grupo-1:0]    g_s;
    logic [Grupo-1:0]    p_s;
    logic [Grupo:0]      cy_s;
    logic [Grupo-1:0]    sum_s;
    logic [LO+Grupo-1:0] s_acc_s;

    if (k == 0) begin : g_src
      // Stage 0 takes the live operands; subtraction becomes A + ~B + ~Cin.
      always_comb begin
        a_in_s  = A;
        bx_in_s = sub ? ~B : B;
        c_in_s  = sub ? ~Cin : Cin;
        v_in_s  = accept_s;
        s_acc_s = sum_s;
      end
    end else begin : g_src
      // Later stages take the previous stage's registered operands and carry.
      always_comb begin
        a_in_s  = stg[k-1].g_mid.op_a_q;
        bx_in_s = stg[k-1].g_mid.op_b_q;
        c_in_s  = stg[k-1].g_mid.cry_q;
        v_in_s  = stg[k-1].g_mid.vld_q;
        s_acc_s = {sum_s, stg[k-1].g_mid.part_q};
      end
    end

    // Group generate/propagate, lookahead carries and group sum bits.
    always_comb begin
      g_s   = a_in_s[Grupo-1:0] & bx_in_s[Grupo-1:0];
      p_s   = a_in_s[Grupo-1:0] ^ bx_in_s[Grupo-1:0];
      cy_s  = lookahead(g_s, p_s, c_in_s);
      sum_s = p_s ^ cy_s[Grupo-1:0];
    end

    if (k < NG - 1) begin : g_mid
      localparam int RW = IW - Grupo;

      logic [RW-1:0]       op_a_q, op_a_d;
      logic [RW-1:0]       op_b_q, op_b_d;
      logic [LO+Grupo-1:0] part_q, part_d;
      logic                cry_q, cry_d;
      logic                vld_q, vld_d;

      // Next-stage payload: upper operand bits, finished sum bits, group carry.
      always_comb begin
        op_a_d = a_in_s[IW-1:Grupo];
        op_b_d = bx_in_s[IW-1:Grupo];
        part_d = s_acc_s;
        cry_d  = cy_s[Grupo];
        vld_d  = v_in_s;
      end

      // Inter-stage register; frozen while the consumer stalls the pipe.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          op_a_q <= '0;
          op_b_q <= '0;
          part_q <= '0;
          cry_q  <= 1'b0;
          vld_q  <= 1'b0;
        end else if (advance_s) begin
          op_a_q <= op_a_d;
          op_b_q <= op_b_d;
          part_q <= part_d;
          cry_q  <= cry_d;
          vld_q  <= vld_d;
        end
      end
    end
  end

  // in_ready stays low until the first edge after reset is released.
  always_comb begin
    rdy_d = 1'b1;
  end

  // Output stage: load result and flags only for a real beat; hold otherwise.
  always_comb begin
    out_valid_d = out_valid_q;
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    if (advance_s) begin
      out_valid_d = stg[NG-1].v_in_s;
      if (stg[NG-1].v_in_s) begin
        s_d    = stg[NG-1].s_acc_s;
        cout_d = stg[NG-1].cy_s[Grupo];
        ovf_d  = stg[NG-1].cy_s[Grupo] ^ stg[NG-1].cy_s[Grupo-1];
        zero_d = ~|stg[NG-1].s_acc_s;
        neg_d  = stg[NG-1].s_acc_s[Ancho-1];
      end else begin
        s_d    = s_q;
        cout_d = cout_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output and ready registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      rdy_q       <= rdy_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
    end
  end

  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign Overflow  = ovf_q;
  assign Zero      = zero_q;
  assign Neg       = neg_q;

endmodule

// File: tb/tb_cla_pipe.sv
// tb_cla_pipe: three instances (8/4, 16/4, 16/16) checked every cycle against
// an arithmetic model of A +/- B +/- Cin with a queue of in-flight beats, plus
// directed literal checks on the 8-bit instance.
module tb_cla_pipe;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        of;
    logic        z;
    logic        n;
  } res_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  iv    = 3'b000;
  logic [2:0]  ci    = 3'b000;
  logic [2:0]  sb    = 3'b000;
  logic [2:0]  ordy  = 3'b111;
  logic [15:0] a_d [3];
  logic [15:0] b_d [3];
  wire  [2:0]  ir, ov, co, of, z, ng;
  wire  [15:0] s_o [3];

  int   n_chk = 0;
  int   n_err = 0;
  logic rel;

  // model state: ring of expected results with advances still needed
  res_t q_r   [3][64];
  int   q_rem [3][64];
  int   q_hd  [3];
  int   q_n   [3];
  int   n_acc [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int W = (g == 0) ? 8 : 16;
    localparam int G = (g == 2) ? 16 : 4;
    wire [W-1:0] s_w;
    cla_pipe #(.Ancho(W), .Grupo(G)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]),
      .A(a_d[g][W-1:0]), .B(b_d[g][W-1:0]), .Cin(ci[g]), .sub(sb[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]), .S(s_w), .Cout(co[g]),
      .Overflow(of[g]), .Zero(z[g]), .Neg(ng[g]));
    assign s_o[g] = 16'(s_w);
  end

  function automatic int dut_w(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic int dut_ng(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 4 : 1);
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic res_t ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic c, input logic s);
    longint m, ua, ub, r, sa, sv, sr;
    res_t   o;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sv = (ub >= m / 2) ? ub - m : ub;
    if (s) begin
      r    = ua - ub - longint'(c);
      o.co = (ua >= ub + longint'(c));
      sr   = sa - sv - longint'(c);
    end else begin
      r    = ua + ub + longint'(c);
      o.co = (r >= m);
      sr   = sa + sv + longint'(c);
    end
    o.s  = 16'(r & (m - 1));
    o.of = (sr < -(m / 2)) || (sr >= m / 2);
    o.z  = (o.s == 16'h0000);
    o.n  = o.s[w-1];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model-side "has seen an edge since reset release"
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rel <= 1'b0;
    else        rel <= 1'b1;
  end

  // Compare process: check every instance each cycle, then advance the model.
  always @(negedge clk) begin
    logic exp_ov, exp_ir, adv;
    int   idx;
    res_t r;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        chk($sformatf("u%0d_rst_valid", i), 32'(ov[i]), 32'd0);
        chk($sformatf("u%0d_rst_ready", i), 32'(ir[i]), 32'd0);
        chk($sformatf("u%0d_rst_S", i), 32'(s_o[i]), 32'd0);
        chk($sformatf("u%0d_rst_flags", i), 32'({co[i], of[i], z[i], ng[i]}), 32'd0);
        q_hd[i] = 0;
        q_n[i]  = 0;
      end else begin
        exp_ov = (q_n[i] > 0) && (q_rem[i][q_hd[i]] == 0);
        adv    = ~exp_ov | ordy[i];
        exp_ir = rel & adv;
        chk($sformatf("u%0d_out_valid", i), 32'(ov[i]), 32'(exp_ov));
        chk($sformatf("u%0d_in_ready", i), 32'(ir[i]), 32'(exp_ir));
        if (exp_ov) begin
          r = q_r[i][q_hd[i]];
          chk($sformatf("u%0d_S", i), 32'(s_o[i]), 32'(r.s));
          chk($sformatf("u%0d_Cout", i), 32'(co[i]), 32'(r.co));
          chk($sformatf("u%0d_Overflow", i), 32'(of[i]), 32'(r.of));
          chk($sformatf("u%0d_Zero", i), 32'(z[i]), 32'(r.z));
          chk($sformatf("u%0d_Neg", i), 32'(ng[i]), 32'(r.n));
        end
        if (exp_ov && ordy[i]) begin
          q_hd[i] = (q_hd[i] + 1) % 64;
          q_n[i]  = q_n[i] - 1;
        end
        if (adv) begin
          for (int j = 0; j < q_n[i]; j++) begin
            idx = (q_hd[i] + j) % 64;
            if (q_rem[i][idx] > 0) q_rem[i][idx] = q_rem[i][idx] - 1;
          end
        end
        if (iv[i] && exp_ir) begin
          idx            = (q_hd[i] + q_n[i]) % 64;
          q_r[i][idx]    = ref_op(dut_w(i), a_d[i], b_d[i], ci[i], sb[i]);
          q_rem[i][idx]  = dut_ng(i) - 1;
          q_n[i]         = q_n[i] + 1;
          n_acc[i]       = n_acc[i] + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat on the 8-bit instance (caller sits just after a rising edge).
  task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    logic ok;
    ok     = 1'b0;
    a_d[0] = 16'(a);
    b_d[0] = 16'(b);
    ci[0]  = c;
    sb[0]  = s;
    iv[0]  = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ir[0]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accepted", 32'(ok), 32'd1);
    step();
    iv[0] = 1'b0;
  endtask

  // Wait for the next 8-bit result and compare it with literal values.
  task automatic expect0(input string nm, input logic [7:0] s, input logic c,
                         input logic o, input logic zz, input logic n);
    logic found;
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ov[0]) begin
        found = 1'b1;
        break;
      end
    end
    chk({nm, "_valid"}, 32'(found), 32'd1);
    if (found) begin
      chk({nm, "_S"}, 32'(s_o[0]), 32'(s));
      chk({nm, "_Cout"}, 32'(co[0]), 32'(c));
      chk({nm, "_Overflow"}, 32'(of[0]), 32'(o));
      chk({nm, "_Zero"}, 32'(z[0]), 32'(zz));
      chk({nm, "_Neg"}, 32'(ng[0]), 32'(n));
    end
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] corner [4];
    corner[0] = 16'h0000;
    corner[1] = 16'hFFFF;
    corner[2] = 16'h8000;
    corner[3] = 16'h7FFF;
    if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
    return 16'($urandom());
  endfunction

  initial begin
    int          ngot, nstale, base1, base2;
    logic        took, started;
    int          hold, idx;
    logic [15:0] got [8];

    for (int i = 0; i < 3; i++) begin
      a_d[i]  = 16'h0000;
      b_d[i]  = 16'h0000;
      q_hd[i] = 0;
      q_n[i]  = 0;
      n_acc[i] = 0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // directed arithmetic on the 8-bit, two-stage instance
    send0(8'h7F, 8'h01, 1'b0, 1'b0);
    expect0("add_7F_01", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    send0(8'h00, 8'h01, 1'b0, 1'b1);
    expect0("sub_00_01", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    send0(8'h80, 8'h01, 1'b0, 1'b1);
    expect0("sub_80_01", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    send0(8'hFF, 8'h00, 1'b1, 1'b0);
    expect0("add_FF_cin", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    step();

    // backpressure: five back-to-back beats, consumer stalls 3 cycles
    idx     = 1;
    a_d[0]  = 16'd1;
    b_d[0]  = 16'd1;
    ci[0]   = 1'b0;
    sb[0]   = 1'b0;
    iv[0]   = 1'b1;
    ordy[0] = 1'b1;
    hold    = 0;
    started = 1'b0;
    ngot    = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      took = iv[0] & ir[0];
      if (hold > 0) begin
        chk("bp_in_ready_held", 32'(ir[0]), 32'd0);
        chk("bp_S_held", 32'(s_o[0]), 32'h02);
      end
      if (ov[0] && ordy[0]) begin
        if (ngot < 8) got[ngot] = s_o[0];
        ngot++;
      end
      step();
      if (took) begin
        idx++;
        if (idx <= 5) begin
          a_d[0] = 16'(idx);
          b_d[0] = 16'(idx);
        end else begin
          iv[0] = 1'b0;
        end
      end
      if (hold > 0) begin
        hold--;
        if (hold == 0) ordy[0] = 1'b1;
      end else if (ov[0] && !started) begin
        started = 1'b1;
        hold    = 3;
        ordy[0] = 1'b0;
      end
    end
    chk("bp_result_count", 32'(ngot), 32'd5);
    for (int k = 0; k < 5 && k < ngot; k++)
      chk($sformatf("bp_result_%0d", k), 32'(got[k]), 32'(2 * (k + 1)));

    // reset with two beats in flight: one at the output, one in stage 0
    ordy[0] = 1'b0;
    send0(8'h11, 8'h22, 1'b0, 1'b0);
    send0(8'h33, 8'h44, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_now_valid", 32'(ov), 32'd0);
    chk("rst_now_S", 32'(s_o[0]), 32'd0);
    chk("rst_now_flags", 32'({co[0], of[0], z[0], ng[0]}), 32'd0);
    chk("rst_now_ready", 32'(ir), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n   = 1'b1;
    ordy[0] = 1'b1;
    nstale  = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (ov[0]) nstale++;
    end
    chk("rst_no_stale_beat", 32'(nstale), 32'd0);

    // randomized traffic on all instances with random stalls and bubbles
    step();
    base1 = n_acc[1];
    base2 = n_acc[2];
    for (int t = 0; t < 30000; t++) begin
      if ((n_acc[1] - base1 >= 2000) && (n_acc[2] - base2 >= 2000)) break;
      for (int i = 0; i < 3; i++) begin
        iv[i]   = ($urandom_range(0, 3) != 0);
        ordy[i] = ($urandom_range(0, 3) != 0);
        a_d[i]  = pick_operand();
        b_d[i]  = pick_operand();
        ci[i]   = 1'($urandom_range(0, 1));
        sb[i]   = 1'($urandom_range(0, 1));
      end
      step();
    end
    chk("rand_beats_16x4", 32'(n_acc[1] - base1 >= 2000), 32'd1);
    chk("rand_beats_16x16", 32'(n_acc[2] - base2 >= 2000), 32'd1);

    // drain and confirm every accepted beat came out
    iv   = 3'b000;
    ordy = 3'b111;
    repeat (10) step();
    for (int i = 0; i < 3; i++)
      chk($sformatf("u%0d_drained", i), 32'(q_n[i]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
